inertial_intf: RTL

INERTIAL_INTF -- requirements
Module: inertial_intf

---
 rtl/inertial_intf_pkg.sv | 42 ++++
 rtl/inertial_intf_spi_mnrch.sv | 79 +++++++
 rtl/inertial_intf.sv | 131 +++++++++++++
 3 files changed

// File: rtl/inertial_intf_pkg.sv
// Shared definitions for the inertial sensor interface: sequencer states,
// IMU command words and the SPI serial-clock divide constants.
// Pure declarations; no logic, no latency, no flow control.
package inertial_intf_pkg;

  // Sequencer states: power-up wait, four config writes, then the read loop.
  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  // Configuration writes, issued once after every reset in this order.
  localparam logic [15:0] CMD_INIT1 = 16'h0D02;  // data-ready interrupt enable
  localparam logic [15:0] CMD_INIT2 = 16'h1053;  // accel 208 Hz
  localparam logic [15:0] CMD_INIT3 = 16'h1150;  // gyro 208 Hz
  localparam logic [15:0] CMD_INIT4 = 16'h1460;  // rounding

  // Register reads: address in the high byte, data comes back in the low byte.
  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

  // SCLK is the MSB of a free-running divider while a frame is active.
  localparam int unsigned SCLK_DIV = 32;
  localparam int unsigned DIV_W    = $clog2(SCLK_DIV);
  // Start in the high half so SCLK idles high for a quarter period before
  // the first fall.
  localparam logic [DIV_W-1:0] DIV_PRELOAD = DIV_W'(SCLK_DIV * 3 / 4 - 1);
  // Last count of the low half: the next edge raises SCLK, so MISO is
  // captured here.
  localparam logic [DIV_W-1:0] DIV_SAMPLE  = DIV_W'(SCLK_DIV / 2 - 1);

endpackage

// File: rtl/inertial_intf_spi_mnrch.sv
// SPI master: one 16-bit MSB-first frame per wrt, SCLK = clk/32 idle high.
// Latency: 520 clk from wrt to done; done and rd_data valid together for 1 clk.
// Backpressure: wrt is ignored while a frame is active; the caller waits for done.
// Ports: clk, rst_n (async active-low); wrt/cmd start a frame; done/rd_data
// report the result; SS_n/SCLK/MOSI/MISO are the serial pins.
module spi_mnrch
  import inertial_intf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  logic             r_active;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_bit_cnt;  // SCLK rises seen so far in this frame
  logic [15:0]      r_shft;     // outgoing command, incoming data fills LSB
  logic             r_miso;     // MISO captured just before the SCLK rise
  logic             r_done;

  logic w_fall;
  logic w_sample;

  assign w_fall   = r_active && (&r_div);
  assign w_sample = r_active && (r_div == DIV_SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shft    <= '0;
      r_miso    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (wrt) begin
          r_active  <= 1'b1;
          r_div     <= DIV_PRELOAD;
          r_bit_cnt <= '0;
          r_shft    <= cmd;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
        if (w_sample) begin
          r_miso    <= MISO;
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        if (w_fall) begin
          if (r_bit_cnt == 5'd16) begin
            // Terminal count: absorb the last sampled bit and end the frame
            // instead of producing a 17th fall.
            r_shft   <= {r_shft[14:0], r_miso};
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end else if (r_bit_cnt != 5'd0) begin
            // The MSB is already on MOSI, so the first fall does not shift.
            r_shft <= {r_shft[14:0], r_miso};
          end
        end
      end
    end
  end

  assign SS_n    = ~r_active;
  assign SCLK    = r_active ? r_div[DIV_W-1] : 1'b1;
  assign MOSI    = r_active ? r_shft[15] : 1'b0;
  assign done    = r_done;
  assign rd_data = r_shft;

endmodule

// File: rtl/inertial_intf.sv
// IMU sequencer: power-up wait, four config writes, then a 4-read burst per INT.
// Latency: vld pulses 1 clk after the done of the last read of a burst.
// Backpressure: none upstream; each SPI command waits for the previous done.
// Ports: clk, rst_n (async active-low); INT async data-ready; SS_n/SCLK/MOSI/
// MISO to the IMU; vld strobes a new coherent ptch_rt/AZ pair.
module inertial_intf
  import inertial_intf_pkg::*;
#(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  state_t            r_state;
  state_t            w_nxt;
  logic [INIT_W-1:0] r_timer;
  logic              r_int_ff1;
  logic              r_int_ff2;
  logic              r_wrt;
  logic [15:0]       r_cmd;
  logic              w_wrt;
  logic [15:0]       w_cmd;
  logic              w_done;
  logic [15:0]       w_rd_data;
  logic [7:0]        r_pl;
  logic [7:0]        r_ph;
  logic [7:0]        r_al;
  logic [15:0]       r_ptch;
  logic [15:0]       r_az;
  logic              r_vld;
  logic              w_unused_hi;

  // Command byte echoes back in the high half of every read; only the low
  // byte carries register data.
  assign w_unused_hi = ^w_rd_data[15:8];

  spi_mnrch u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (r_wrt),
    .cmd     (r_cmd),
    .done    (w_done),
    .rd_data (w_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Next state and the command to launch on that transition. Launching only
  // on transitions gives exactly one wrt per frame, and it reaches the SPI
  // engine one clk after done, when the engine is already idle.
  always_comb begin
    w_nxt = r_state;
    w_wrt = 1'b0;
    w_cmd = 16'h0000;
    case (r_state)
      INIT_WAIT: if (&r_timer) begin w_nxt = INIT1; w_wrt = 1'b1; w_cmd = CMD_INIT1; end
      INIT1:     if (w_done)   begin w_nxt = INIT2; w_wrt = 1'b1; w_cmd = CMD_INIT2; end
      INIT2:     if (w_done)   begin w_nxt = INIT3; w_wrt = 1'b1; w_cmd = CMD_INIT3; end
      INIT3:     if (w_done)   begin w_nxt = INIT4; w_wrt = 1'b1; w_cmd = CMD_INIT4; end
      INIT4:     if (w_done)   begin w_nxt = IDLE; end
      // INT is only looked at here, so edges during a burst are ignored and a
      // level still high after the burst starts the next one right away.
      IDLE:      if (r_int_ff2) begin w_nxt = RD_PL; w_wrt = 1'b1; w_cmd = CMD_RD_PL; end
      RD_PL:     if (w_done)   begin w_nxt = RD_PH; w_wrt = 1'b1; w_cmd = CMD_RD_PH; end
      RD_PH:     if (w_done)   begin w_nxt = RD_AL; w_wrt = 1'b1; w_cmd = CMD_RD_AL; end
      RD_AL:     if (w_done)   begin w_nxt = RD_AH; w_wrt = 1'b1; w_cmd = CMD_RD_AH; end
      RD_AH:     if (w_done)   begin w_nxt = IDLE; end
      default:   w_nxt = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT_WAIT;
      r_timer   <= '0;
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_wrt     <= 1'b0;
      r_cmd     <= 16'h0000;
      r_pl      <= 8'h00;
      r_ph      <= 8'h00;
      r_al      <= 8'h00;
      r_ptch    <= 16'h0000;
      r_az      <= 16'h0000;
      r_vld     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      r_wrt     <= w_wrt;
      if (w_wrt) begin
        r_cmd <= w_cmd;
      end
      if ((r_state == INIT_WAIT) && !(&r_timer)) begin
        r_timer <= r_timer + INIT_W'(1);
      end
      r_vld <= 1'b0;
      if (w_done) begin
        case (r_state)
          RD_PL: r_pl <= w_rd_data[7:0];
          RD_PH: r_ph <= w_rd_data[7:0];
          RD_AL: r_al <= w_rd_data[7:0];
          // Both outputs load on the same edge from the held bytes, so a
          // reader never sees half of an old pair and half of a new one.
          RD_AH: begin
            r_ptch <= {r_ph, r_pl};
            r_az   <= {w_rd_data[7:0], r_al};
            r_vld  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign vld     = r_vld;
  assign ptch_rt = r_ptch;
  assign AZ      = r_az;

endmodule
